// File: rtl/sync_fifo_param.sv
// Single-clock parametrised FIFO with show-ahead read data, occupancy count and almost flags.
// Define SYNC_FIFO_ERR_EN to add sticky overflow/underflow flags with an err_clr input.
module sync_fifo_param #(
  parameter int DSIZE     = 8,
  parameter int ASIZE     = 4,
  parameter int AFULL_TH  = 12,
  parameter int AEMPTY_TH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [DSIZE-1:0] wdata,
  input  logic             winc,
  input  logic             rinc,
`ifdef SYNC_FIFO_ERR_EN
  input  logic             err_clr,
  output logic             overflow,
  output logic             underflow,
`endif
  output logic [DSIZE-1:0] rdata,
  output logic             wfull,
  output logic             rempty,
  output logic             almost_full,
  output logic             almost_empty,
  output logic [ASIZE:0]   count
);

  localparam int DEPTH = 1 << ASIZE;
  localparam logic [ASIZE:0] AFULL_LVL  = (ASIZE+1)'(AFULL_TH);
  localparam logic [ASIZE:0] AEMPTY_LVL = (ASIZE+1)'(AEMPTY_TH);

  logic [DSIZE-1:0] mem [DEPTH];
  logic [ASIZE:0]   wptr_reg, rptr_reg, count_reg, count_next;
  logic             wa, ra;

  assign wa = winc & ~wfull;
  assign ra = rinc & ~rempty;

  // Storage is deliberately left out of reset; read is asynchronous for show-ahead.
  always_ff @(posedge clk) begin
    if (wa) mem[wptr_reg[ASIZE-1:0]] <= wdata;
  end

  assign rdata = mem[rptr_reg[ASIZE-1:0]];

  always_comb begin
    count_next = count_reg;
    case ({wa, ra})
      2'b10:   count_next = count_reg + 1'b1;
      2'b01:   count_next = count_reg - 1'b1;
      default: count_next = count_reg;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr_reg  <= '0;
      rptr_reg  <= '0;
      count_reg <= '0;
    end else begin
      if (wa) wptr_reg <= wptr_reg + 1'b1;
      if (ra) rptr_reg <= rptr_reg + 1'b1;
      count_reg <= count_next;
    end
  end

  // Full when the pointers address the same word but sit on different laps.
  assign wfull  = (wptr_reg[ASIZE] != rptr_reg[ASIZE]) &&
                  (wptr_reg[ASIZE-1:0] == rptr_reg[ASIZE-1:0]);
  assign rempty = (wptr_reg == rptr_reg);

  assign almost_full  = (count_reg >= AFULL_LVL);
  assign almost_empty = (count_reg <= AEMPTY_LVL);
  assign count        = count_reg;

`ifdef SYNC_FIFO_ERR_EN
  logic overflow_reg, underflow_reg;

  // A new violation in the same cycle as err_clr keeps the flag set.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      overflow_reg  <= 1'b0;
      underflow_reg <= 1'b0;
    end else begin
      overflow_reg  <= (winc & wfull)  | (overflow_reg  & ~err_clr);
      underflow_reg <= (rinc & rempty) | (underflow_reg & ~err_clr);
    end
  end

  assign overflow  = overflow_reg;
  assign underflow = underflow_reg;
`endif

endmodule

// File: tb/tb_sync_fifo_param.sv
// Randomised and directed bench for sync_fifo_param against a queue-based occupancy model.
// Honours SYNC_FIFO_ERR_EN to exercise the sticky error flags when that build is selected.
module tb_sync_fifo_param;

  localparam int DEPTH = 16;

  logic       clk, rst_n, winc, rinc;
  logic [7:0] wdata, rdata;
  logic       wfull, rempty, almost_full, almost_empty;
  logic [4:0] count;
`ifdef SYNC_FIFO_ERR_EN
  logic       err_clr, overflow, underflow;
  bit         ovf_m, udf_m;
`endif

  int pass_cnt  = 0;
  int total_cnt = 0;
  bit chk_en    = 0;
  logic [7:0] q[$];

  sync_fifo_param #(.DSIZE(8), .ASIZE(4), .AFULL_TH(12), .AEMPTY_TH(4)) dut (
    .clk(clk), .rst_n(rst_n), .wdata(wdata), .winc(winc), .rinc(rinc),
`ifdef SYNC_FIFO_ERR_EN
    .err_clr(err_clr), .overflow(overflow), .underflow(underflow),
`endif
    .rdata(rdata), .wfull(wfull), .rempty(rempty),
    .almost_full(almost_full), .almost_empty(almost_empty), .count(count)
  );

  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act !== exp) $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    else pass_cnt++;
  endtask

  // Reference: FIFO contents as a queue; acceptance derived from its size only.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q.delete();
`ifdef SYNC_FIFO_ERR_EN
      ovf_m = 0;
      udf_m = 0;
`endif
    end else begin
      int  sz;
      bit  full_m, empty_m;
      sz      = q.size();
      full_m  = (sz == DEPTH);
      empty_m = (sz == 0);
`ifdef SYNC_FIFO_ERR_EN
      if (winc && full_m) ovf_m = 1; else if (err_clr) ovf_m = 0;
      if (rinc && empty_m) udf_m = 1; else if (err_clr) udf_m = 0;
`endif
      if (rinc && !empty_m) void'(q.pop_front());
      if (winc && !full_m) q.push_back(wdata);
    end
  end

  always @(negedge clk) begin
    if (rst_n && chk_en) begin
      int sz;
      sz = q.size();
      chk("count", 32'(count), 32'(sz));
      chk("rempty", 32'(rempty), 32'(sz == 0));
      chk("wfull", 32'(wfull), 32'(sz == DEPTH));
      chk("almost_full", 32'(almost_full), 32'(sz >= 12));
      chk("almost_empty", 32'(almost_empty), 32'(sz <= 4));
      if (sz > 0) chk("rdata", 32'(rdata), 32'(q[0]));
`ifdef SYNC_FIFO_ERR_EN
      chk("overflow", 32'(overflow), 32'(ovf_m));
      chk("underflow", 32'(underflow), 32'(udf_m));
`endif
      $display("t=%0t w=%0b r=%0b wd=%02h cnt=%0d rd=%02h", $time, winc, rinc, wdata, count, rdata);
    end
  end

  task automatic cyc(input logic w, input logic r, input logic [7:0] d);
    winc  = w;
    rinc  = r;
    wdata = d;
    @(posedge clk);
    #1;
    winc = 0;
    rinc = 0;
  endtask

  initial begin
    rst_n = 0; winc = 0; rinc = 0; wdata = 0;
`ifdef SYNC_FIFO_ERR_EN
    err_clr = 0;
`endif
    #12 rst_n = 1;
    #1;
    chk("rst_rempty", 32'(rempty), 1);
    chk("rst_wfull", 32'(wfull), 0);
    chk("rst_count", 32'(count), 0);
    chk("rst_aempty", 32'(almost_empty), 1);
    chk("rst_afull", 32'(almost_full), 0);
    chk_en = 1;

    // Fill with 0x01..0x10, watching almost_full turn on at the 12th write.
    for (int i = 1; i <= 16; i++) begin
      cyc(1, 0, 8'(i));
      if (i == 11) chk("afull_at_11", 32'(almost_full), 0);
      if (i == 12) chk("afull_at_12", 32'(almost_full), 1);
    end
    chk("fill_count", 32'(count), 16);
    chk("fill_wfull", 32'(wfull), 1);
    for (int i = 1; i <= 16; i++) begin
      chk("drain_rdata", 32'(rdata), 32'(i));
      cyc(0, 1, 8'h00);
    end
    chk("drain_rempty", 32'(rempty), 1);

    // Simultaneous request while full, then while empty.
    for (int i = 1; i <= 16; i++) cyc(1, 0, 8'(i));
    cyc(1, 1, 8'hAA);
    chk("full_rw_count", 32'(count), 15);
    chk("full_rw_head", 32'(rdata), 2);
    for (int i = 0; i < 15; i++) cyc(0, 1, 8'h00);
    chk("full_rw_noaa", 32'(rempty), 1);
    cyc(1, 1, 8'h55);
    chk("empty_rw_count", 32'(count), 1);
    chk("empty_rw_rdata", 32'(rdata), 8'h55);
    cyc(0, 1, 8'h00);

    // Hold occupancy at 8 across pointer wrap.
    for (int i = 0; i < 8; i++) cyc(1, 0, 8'(8'h20 + i));
    for (int i = 0; i < 40; i++) cyc(1, 1, 8'(8'h40 + i));
    chk("steady_count", 32'(count), 8);
    chk("steady_head", 32'(rdata), 8'h40 + 32);
    for (int i = 0; i < 8; i++) cyc(0, 1, 8'h00);

    // Asynchronous reset mid-burst at occupancy 9.
    for (int i = 0; i < 9; i++) cyc(1, 0, 8'(8'h90 + i));
    winc = 1; wdata = 8'hEE;
    #3 rst_n = 0;
    #1;
    chk("async_count", 32'(count), 0);
    chk("async_rempty", 32'(rempty), 1);
    winc = 0;
    #2 rst_n = 1;
    cyc(1, 0, 8'h77);
    chk("post_rst_rdata", 32'(rdata), 8'h77);
    chk("post_rst_count", 32'(count), 1);
    cyc(0, 1, 8'h00);

`ifdef SYNC_FIFO_ERR_EN
    for (int i = 0; i < 16; i++) cyc(1, 0, 8'(i));
    cyc(1, 0, 8'hBB);
    chk("ovf_set", 32'(overflow), 1);
    chk("ovf_count", 32'(count), 16);
    for (int i = 0; i < 16; i++) cyc(0, 1, 8'h00);
    cyc(0, 1, 8'h00);
    chk("udf_set", 32'(underflow), 1);
    err_clr = 1;
    cyc(0, 0, 8'h00);
    err_clr = 0;
    chk("ovf_clr", 32'(overflow), 0);
    chk("udf_clr", 32'(underflow), 0);
`endif

    // Random traffic with alternating write-heavy, read-heavy and balanced phases.
    for (int i = 0; i < 1500; i++) begin
      int wp;
      int mode;
      mode = (i / 150) % 3;
      wp = (mode == 0) ? 80 : ((mode == 1) ? 20 : 50);
`ifdef SYNC_FIFO_ERR_EN
      err_clr = ($urandom_range(15) == 0);
`endif
      cyc($urandom_range(99) < wp, $urandom_range(99) < (100 - wp), 8'($urandom));
    end
`ifdef SYNC_FIFO_ERR_EN
    err_clr = 0;
`endif
    cyc(0, 0, 8'h00);
    chk_en = 0;
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
